// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM states and opcode-class helpers for alu_mc.
// Divider opcodes are iterative only when ALU_MC_DIV_EN is defined.
package alu_mc_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_MULHU = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
`else
    return op inside {OP_MUL, OP_MULHU};
`endif
  endfunction

`ifdef ALU_MC_DIV_EN
  function automatic logic is_div(input logic [3:0] op);
    return op inside {OP_DIVU, OP_REMU};
  endfunction
`endif

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the ID/EX latch, alu_mc and writeback.
interface alu_mc_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [3:0]            ALUop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Overflow;
  logic                  CarryOut;
  logic                  Zero;

  modport master (
    output in_valid, A, B, ALUop, out_ready,
    input  in_ready, out_valid, Result, Overflow, CarryOut, Zero
  );

  modport slave (
    input  in_valid, A, B, ALUop, out_ready,
    output in_ready, out_valid, Result, Overflow, CarryOut, Zero
  );
endinterface

// File: rtl/alu_mc_iter.sv
// Iterative datapath: radix-2 shift-add multiplier and, with ALU_MC_DIV_EN,
// a restoring divider; one bit per clock, DATA_WIDTH clocks per operation.
module alu_mc_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  import alu_mc_pkg::*;

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc, acc_src, acc_step;
  logic [W-1:0]    opnd, opnd_src;
  logic [3:0]      op_r;
  logic [W:0]      hi_sum;
`ifdef ALU_MC_DIV_EN
  logic            div_mode;
  logic [W:0]      rem_sh, diff;
`endif

  // The first iteration runs on the accept edge straight from the operands,
  // so the last one lands one clock before the top registers the result.
  always_comb begin
    acc_src  = acc;
    opnd_src = opnd;
    if (start) begin
      acc_src  = {{W{1'b0}}, B};
      opnd_src = A;
`ifdef ALU_MC_DIV_EN
      if (is_div(op)) begin
        acc_src  = {{W{1'b0}}, A};
        opnd_src = B;
      end
`endif
    end
  end

  always_comb begin
    hi_sum   = {1'b0, acc_src[2*W-1:W]} + (acc_src[0] ? {1'b0, opnd_src} : '0);
    acc_step = {hi_sum, acc_src[W-1:1]};
`ifdef ALU_MC_DIV_EN
    div_mode = start ? is_div(op) : is_div(op_r);
    rem_sh   = {acc_src[2*W-1:W], acc_src[W-1]};
    diff     = rem_sh - {1'b0, opnd_src};
    if (div_mode) begin
      acc_step = diff[W] ? {rem_sh[W-1:0], acc_src[W-2:0], 1'b0}
                         : {diff[W-1:0],   acc_src[W-2:0], 1'b1};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      opnd <= '0;
      op_r <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= CW'(1);
        acc  <= acc_step;
        opnd <= opnd_src;
        op_r <= op;
      end else if (busy) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // acc holds {high, low} for multiply and {remainder, quotient} for divide.
  always_comb begin
    result = acc[W-1:0];
    if (op_r == OP_MULHU) result = acc[2*W-1:W];
`ifdef ALU_MC_DIV_EN
    if (op_r == OP_REMU) result = acc[2*W-1:W];
    if (op_r == OP_DIVU && opnd == '0) result = '1;
`endif
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready on both sides, registered Result and flags,
// iterative MUL/MULHU (DIVU/REMU when ALU_MC_DIV_EN is defined).
module alu_mc #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  import alu_mc_pkg::*;

  localparam int unsigned W = DATA_WIDTH;

  state_t             state, state_nxt;
  logic               in_ready, accept, op_iter, iter_start, iter_done;
  logic [W-1:0]       iter_result, sc_result, res_q;
  logic               sc_ovf, sc_cout, ovf_q, cout_q, zero_q;
  logic [W:0]         sum_add, sum_sub;
  logic               ovf_add, ovf_sub, borrow;
  logic [SHAMT_W-1:0] shamt;

  assign op_iter    = is_iterative(bus.ALUop);
  assign in_ready   = (state == IDLE) || (state == DONE && bus.out_ready);
  assign accept     = bus.in_valid && in_ready;
  assign iter_start = accept && op_iter;
  assign shamt      = bus.B[SHAMT_W-1:0];

  assign sum_add = {1'b0, bus.A} + {1'b0, bus.B};
  assign sum_sub = {1'b0, bus.A} + {1'b0, ~bus.B} + {{W{1'b0}}, 1'b1};
  assign ovf_add = (bus.A[W-1] == bus.B[W-1]) && (sum_add[W-1] != bus.A[W-1]);
  assign ovf_sub = (bus.A[W-1] != bus.B[W-1]) && (sum_sub[W-1] != bus.A[W-1]);
  assign borrow  = ~sum_sub[W];

  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_cout   = 1'b0;
    case (bus.ALUop)
      OP_AND:  sc_result = bus.A & bus.B;
      OP_OR:   sc_result = bus.A | bus.B;
      OP_XOR:  sc_result = bus.A ^ bus.B;
      OP_NOR:  sc_result = ~(bus.A | bus.B);
      OP_ADD: begin
        sc_result = sum_add[W-1:0];
        sc_ovf    = ovf_add;
        sc_cout   = sum_add[W];
      end
      OP_SUB: begin
        sc_result = sum_sub[W-1:0];
        sc_ovf    = ovf_sub;
        sc_cout   = borrow;
      end
      OP_SLT: begin
        sc_result = {{(W-1){1'b0}}, sum_sub[W-1] ^ ovf_sub};
        sc_ovf    = ovf_sub;
        sc_cout   = borrow;
      end
      OP_SLTU: begin
        sc_result = {{(W-1){1'b0}}, borrow};
        sc_cout   = borrow;
      end
      OP_SLL:  sc_result = bus.A << shamt;
      OP_SRL:  sc_result = bus.A >> shamt;
      OP_SRA:  sc_result = $unsigned($signed(bus.A) >>> shamt);
      default: sc_result = '0;
    endcase
  end

  alu_mc_iter #(
    .DATA_WIDTH(W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .op     (bus.ALUop),
    .A      (bus.A),
    .B      (bus.B),
    .done   (iter_done),
    .result (iter_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = op_iter ? BUSY : DONE;
      BUSY: if (iter_done) state_nxt = DONE;
      DONE: begin
        if (accept)             state_nxt = op_iter ? BUSY : DONE;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers only change on a new single-cycle accept or iterative
  // completion, so they hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept && !op_iter) begin
      res_q  <= sc_result;
      ovf_q  <= sc_ovf;
      cout_q <= sc_cout;
      zero_q <= (sc_result == '0);
    end else if (state == BUSY && iter_done) begin
      res_q  <= iter_result;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= (iter_result == '0);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.Result    = res_q;
  assign bus.Overflow  = ovf_q;
  assign bus.CarryOut  = cout_q;
  assign bus.Zero      = zero_q;

endmodule
